// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control unit.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN (illegal-decode flag output).
package alu_ctrl_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned SEL_W  = 9;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [SEL_W-1:0]  sel_t;

    localparam code_t OP_AND      = 4'b0000;
    localparam code_t OP_OR       = 4'b0001;
    localparam code_t OP_NOR      = 4'b0010;
    localparam code_t OP_ADD      = 4'b0011;
    localparam code_t OP_SUB      = 4'b0100;
    localparam code_t OP_LUI      = 4'b0101;
    localparam code_t OP_SLL      = 4'b0110;
    localparam code_t OP_SRL      = 4'b0111;
    localparam code_t OP_MUL_STEP = 4'b1000;
    localparam code_t OP_DEFAULT  = 4'b1001;
    localparam code_t OP_DIV_STEP = 4'b1010;
    localparam code_t OP_MD_DONE  = 4'b1011;

    // {alu_op[2:0], funct[5:0]} selectors; I-type entries ignore funct
    localparam sel_t SEL_AND   = 9'b111_100100;
    localparam sel_t SEL_OR    = 9'b111_100101;
    localparam sel_t SEL_NOR   = 9'b111_100111;
    localparam sel_t SEL_ADD   = 9'b111_100000;
    localparam sel_t SEL_SUB   = 9'b111_100010;
    localparam sel_t SEL_SLL   = 9'b111_000000;
    localparam sel_t SEL_SRL   = 9'b111_000010;
    localparam sel_t SEL_MULT  = 9'b111_011000;
    localparam sel_t SEL_MULTU = 9'b111_011001;
    localparam sel_t SEL_DIV   = 9'b111_011010;
    localparam sel_t SEL_DIVU  = 9'b111_011011;
    localparam sel_t SEL_ADDI  = 9'b100_??????;
    localparam sel_t SEL_ORI   = 9'b101_??????;
    localparam sel_t SEL_ANDI  = 9'b110_??????;
    localparam sel_t SEL_LUI   = 9'b011_??????;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ITER   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef struct packed {
        code_t code;
        logic  is_md;
        logic  is_signed;
        logic  is_illegal;
    } dec_t;

    function automatic logic is_muldiv(sel_t sel);
        return (sel == SEL_MULT) || (sel == SEL_MULTU) ||
               (sel == SEL_DIV)  || (sel == SEL_DIVU);
    endfunction

    function automatic logic is_signed_md(sel_t sel);
        return (sel == SEL_MULT) || (sel == SEL_DIV);
    endfunction

endpackage

// File: rtl/alu_control_mc_if.sv
// Issue-side bus of the ALU control unit: request handshake, decode result, mult/div status.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN adds illegal_o.
interface alu_control_mc_if #(
    parameter int unsigned ALUOP_W   = 3,
    parameter int unsigned FUNCT_W   = 6,
    parameter int unsigned OPER_W    = 4,
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1
);
    logic               valid_i;
    logic               ready_o;
    logic [ALUOP_W-1:0] alu_op;
    logic [FUNCT_W-1:0] alu_function;
    logic               flush_i;
    logic               valid_o;
    logic [OPER_W-1:0]  alu_operation;
    logic               busy_o;
    logic               md_signed_o;
    logic [CNT_W-1:0]   step_idx_o;
    logic               hilo_we_o;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic               illegal_o;
`endif

    modport master (
        output valid_i, alu_op, alu_function, flush_i,
`ifdef ALU_CTRL_ILLEGAL_EN
        input  illegal_o,
`endif
        input  ready_o, valid_o, alu_operation, busy_o, md_signed_o, step_idx_o, hilo_we_o
    );

    modport slave (
        input  valid_i, alu_op, alu_function, flush_i,
`ifdef ALU_CTRL_ILLEGAL_EN
        output illegal_o,
`endif
        output ready_o, valid_o, alu_operation, busy_o, md_signed_o, step_idx_o, hilo_we_o
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of {alu_op, funct} into operation code and mult/div attributes.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN (consumer of is_illegal lives in the top).
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned FUNCT_W = 6
) (
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic [FUNCT_W-1:0] alu_function,
    output dec_t               dec_c
);

    localparam int unsigned OP_SEL_W = 3;
    localparam int unsigned FN_SEL_W = 6;

    logic op_fits_c;
    logic fn_fits_c;
    sel_t sel_c;

    // Fields that do not fit the 9-bit selector are forced onto encodings that decode as DEFAULT
    always_comb begin
        op_fits_c = (ALUOP_W'(OP_SEL_W'(alu_op)) == alu_op);
        fn_fits_c = (FUNCT_W'(FN_SEL_W'(alu_function)) == alu_function);
        sel_c     = {op_fits_c ? OP_SEL_W'(alu_op) : 3'b000,
                     fn_fits_c ? FN_SEL_W'(alu_function) : 6'b111111};
    end

    always_comb begin
        dec_c = '0;
        casez (sel_c)
            SEL_AND:             dec_c.code = OP_AND;
            SEL_OR:              dec_c.code = OP_OR;
            SEL_NOR:             dec_c.code = OP_NOR;
            SEL_ADD:             dec_c.code = OP_ADD;
            SEL_SUB:             dec_c.code = OP_SUB;
            SEL_SLL:             dec_c.code = OP_SLL;
            SEL_SRL:             dec_c.code = OP_SRL;
            SEL_MULT, SEL_MULTU: dec_c.code = OP_MUL_STEP;
            SEL_DIV, SEL_DIVU:   dec_c.code = OP_DIV_STEP;
            SEL_ADDI:            dec_c.code = OP_ADD;
            SEL_ORI:             dec_c.code = OP_OR;
            SEL_ANDI:            dec_c.code = OP_AND;
            SEL_LUI:             dec_c.code = OP_LUI;
            default:             dec_c.code = OP_DEFAULT;
        endcase
        dec_c.is_illegal = (dec_c.code == OP_DEFAULT);
        dec_c.is_md      = is_muldiv(sel_c);
        dec_c.is_signed  = is_signed_md(sel_c);
    end

endmodule

// File: rtl/alu_control_mc.sv
// Registered ALU control: single-cycle decode plus iterative mult/div sequencing.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN adds a registered illegal_o flag.
module alu_control_mc
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W   = 3,
    parameter int unsigned FUNCT_W   = 6,
    parameter int unsigned OPER_W    = 4,
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_control_mc_if.slave  bus
);

    state_t            state_q;
    state_t            state_n;
    dec_t              dec_c;
    logic              accept_c;
    logic              start_md_c;
    logic              last_step_c;

    logic [OPER_W-1:0] op_q,     op_d;
    logic              valid_q,  valid_d;
    logic              busy_q,   busy_d;
    logic              signed_q, signed_d;
    logic              hilo_q,   hilo_d;
    logic [CNT_W-1:0]  step_q,   step_d;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic              illegal_q, illegal_d;
`endif

    alu_ctrl_decode #(
        .ALUOP_W (ALUOP_W),
        .FUNCT_W (FUNCT_W)
    ) u_decode (
        .alu_op       (bus.alu_op),
        .alu_function (bus.alu_function),
        .dec_c        (dec_c)
    );

    always_comb begin
        accept_c    = bus.valid_i && (state_q == ST_IDLE) && !bus.flush_i;
        start_md_c  = accept_c && dec_c.is_md && !dec_c.is_illegal;
        last_step_c = (state_q == ST_ITER) && (step_q == CNT_W'(MD_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        if (bus.flush_i) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (start_md_c)  state_n = ST_ITER;
                ST_ITER:   if (last_step_c) state_n = ST_FINISH;
                ST_FINISH: state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; a flush leaves every pulse at its default of 0
    always_comb begin
        op_d     = op_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        signed_d = 1'b0;
        hilo_d   = 1'b0;
        step_d   = '0;
`ifdef ALU_CTRL_ILLEGAL_EN
        illegal_d = 1'b0;
`endif
        if (!bus.flush_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_d = OPER_W'(dec_c.code);
                        if (start_md_c) begin
                            busy_d   = 1'b1;
                            signed_d = dec_c.is_signed;
                        end else begin
                            valid_d = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_EN
                            illegal_d = dec_c.is_illegal;
`endif
                        end
                    end
                end
                ST_ITER: begin
                    busy_d   = 1'b1;
                    signed_d = signed_q;
                    if (last_step_c) begin
                        op_d    = OPER_W'(OP_MD_DONE);
                        valid_d = 1'b1;
                        hilo_d  = 1'b1;
                    end else begin
                        step_d = step_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OPER_W'(OP_DEFAULT);
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            signed_q <= 1'b0;
            hilo_q   <= 1'b0;
            step_q   <= '0;
`ifdef ALU_CTRL_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            op_q     <= op_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            signed_q <= signed_d;
            hilo_q   <= hilo_d;
            step_q   <= step_d;
`ifdef ALU_CTRL_ILLEGAL_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.ready_o       = (state_q == ST_IDLE);
    assign bus.alu_operation = op_q;
    assign bus.valid_o       = valid_q;
    assign bus.busy_o        = busy_q;
    assign bus.md_signed_o   = signed_q;
    assign bus.hilo_we_o     = hilo_q;
    assign bus.step_idx_o    = step_q;
`ifdef ALU_CTRL_ILLEGAL_EN
    assign bus.illegal_o     = illegal_q;
`endif

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc with a transaction-level reference model.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN enables illegal_o checks.
module tb_alu_control_mc;

    localparam int MDC = 4;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] m_code;

    logic [5:0] rfn [11] = '{6'd36, 6'd37, 6'd39, 6'd32, 6'd34, 6'd0, 6'd2,
                             6'd24, 6'd25, 6'd26, 6'd27};

    always #5 clk = ~clk;

    alu_control_mc_if #(.MD_CYCLES(MDC)) bus ();

    alu_control_mc #(.MD_CYCLES(MDC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {valid, busy, hilo_we, ready, md_signed, alu_operation, step_idx}
    function automatic logic [10:0] obs();
        return {bus.valid_o, bus.busy_o, bus.hilo_we_o, bus.ready_o, bus.md_signed_o,
                bus.alu_operation, bus.step_idx_o};
    endfunction

    // Reference decode straight from the opcode table
    function automatic void ref_decode(input logic [2:0] op, input logic [5:0] fn,
                                       output logic [3:0] code, output logic md,
                                       output logic sg);
        md = 1'b0;
        sg = 1'b0;
        code = 4'd9;
        if (op == 3'd7) begin
            case (fn)
                6'd36: code = 4'd0;
                6'd37: code = 4'd1;
                6'd39: code = 4'd2;
                6'd32: code = 4'd3;
                6'd34: code = 4'd4;
                6'd0:  code = 4'd6;
                6'd2:  code = 4'd7;
                6'd24: begin code = 4'd8;  md = 1'b1; sg = 1'b1; end
                6'd25: begin code = 4'd8;  md = 1'b1; end
                6'd26: begin code = 4'd10; md = 1'b1; sg = 1'b1; end
                6'd27: begin code = 4'd10; md = 1'b1; end
                default: code = 4'd9;
            endcase
        end else if (op == 3'd4) code = 4'd3;
        else if (op == 3'd5) code = 4'd1;
        else if (op == 3'd6) code = 4'd0;
        else if (op == 3'd3) code = 4'd5;
    endfunction

    task automatic md_sequence(input logic [2:0] op, input logic [5:0] fn, input int flush_at,
                               input bit hold_add, input string nm);
        logic [3:0]  sc;
        logic        md;
        logic        sg;
        logic [10:0] got;
        logic [10:0] exp;
        ref_decode(op, fn, sc, md, sg);
        bus.valid_i = 1'b1;
        bus.alu_op = op;
        bus.alu_function = fn;
        tick();
        bus.valid_i = hold_add;
        if (hold_add) begin
            bus.alu_op = 3'd7;
            bus.alu_function = 6'd32;
        end
        for (int k = 0; k < MDC; k++) begin
            got = obs();
            exp = {4'b0100, sg, sc, CW'(k)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s_iter%0d got=%b want=%b", nm, k, got, exp);
            end
            if (k == flush_at) begin
                bus.flush_i = 1'b1;
                tick();
                bus.flush_i = 1'b0;
                got = obs();
                exp = {4'b0001, 1'b0, sc, 2'b00};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL %s_flush got=%b want=%b", nm, got, exp);
                end
                m_code = sc;
                return;
            end
            tick();
        end
        got = obs();
        got[1:0] = 2'b00;
        exp = {4'b1110, sg, 4'b1011, 2'b00};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s_finish got=%b want=%b", nm, got, exp);
        end
        tick();
        got = obs();
        exp = {4'b0001, 1'b0, 4'b1011, 2'b00};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s_idle got=%b want=%b", nm, got, exp);
        end
        m_code = 4'd11;
        if (hold_add) begin
            tick();
            bus.valid_i = 1'b0;
            got = obs();
            exp = {4'b1001, 1'b0, 4'b0011, 2'b00};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s_held_add got=%b want=%b", nm, got, exp);
            end
            m_code = 4'd3;
        end
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        reset = 1'b1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.alu_op = 3'd0;
        bus.alu_function = 6'd0;
        repeat (3) tick();
        exp = {4'b0001, 1'b0, 4'b1001, 2'b00};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL reset_held got=%b want=%b", obs(), exp);
        end
        reset = 1'b0;
        tick();
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", obs(), exp);
        end
`ifdef ALU_CTRL_ILLEGAL_EN
        total++;
        if (bus.illegal_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_illegal got=%b want=0", bus.illegal_o);
        end
`endif
        m_code = 4'd9;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3] = '{3'd7, 3'd7, 3'd5};
        logic [5:0]  fns [3];
        logic [3:0]  want [3] = '{4'b0011, 4'b0100, 4'b0001};
        logic [10:0] exp;
        fns[0] = 6'd32;
        fns[1] = 6'd34;
        fns[2] = 6'($urandom);
        for (int i = 0; i < 3; i++) begin
            bus.valid_i = 1'b1;
            bus.alu_op = ops[i];
            bus.alu_function = fns[i];
            tick();
            exp = {4'b1001, 1'b0, want[i], 2'b00};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL b2b_%0d got=%b want=%b", i, obs(), exp);
            end
        end
        bus.valid_i = 1'b0;
        tick();
        exp = {4'b0001, 1'b0, 4'b0001, 2'b00};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL b2b_hold got=%b want=%b", obs(), exp);
        end
        m_code = 4'b0001;
    endtask

    task automatic test_mult();
        md_sequence(3'd7, 6'd24, -1, 1'b0, "mult");
    endtask

    task automatic test_divu_flush();
        logic [10:0] exp;
        md_sequence(3'd7, 6'd27, 2, 1'b0, "divu");
        bus.valid_i = 1'b1;
        bus.alu_op = 3'd7;
        bus.alu_function = 6'd36;
        tick();
        bus.valid_i = 1'b0;
        exp = {4'b1001, 1'b0, 4'b0000, 2'b00};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL and_after_flush got=%b want=%b", obs(), exp);
        end
        m_code = 4'b0000;
    endtask

    task automatic test_hold_during_iter();
        md_sequence(3'd7, 6'd25, -1, 1'b1, "multu_hold");
    endtask

    task automatic test_flush_idle();
        logic [10:0] exp;
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.alu_op = 3'd7;
        bus.alu_function = 6'd34;
        tick();
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        exp = {4'b0001, 1'b0, m_code, 2'b00};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL flush_idle got=%b want=%b", obs(), exp);
        end
    endtask

    task automatic test_illegal();
        logic [10:0] exp;
        bus.valid_i = 1'b1;
        bus.alu_op = 3'd7;
        bus.alu_function = 6'd63;
        tick();
        bus.valid_i = 1'b0;
        exp = {4'b1001, 1'b0, 4'b1001, 2'b00};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL illegal got=%b want=%b", obs(), exp);
        end
`ifdef ALU_CTRL_ILLEGAL_EN
        total++;
        if (bus.illegal_o !== 1'b1) begin
            bad++;
            $display("FAIL illegal_flag got=%b want=1", bus.illegal_o);
        end
`endif
        tick();
        exp = {4'b0001, 1'b0, 4'b1001, 2'b00};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL illegal_after got=%b want=%b", obs(), exp);
        end
        m_code = 4'b1001;
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp;
        bus.valid_i = 1'b1;
        bus.alu_op = 3'd7;
        bus.alu_function = 6'd26;
        tick();
        bus.valid_i = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp = {4'b0001, 1'b0, 4'b1001, 2'b00};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL reset_mid got=%b want=%b", obs(), exp);
        end
        tick();
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL reset_mid_after got=%b want=%b", obs(), exp);
        end
        m_code = 4'b1001;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [3:0]  code;
        logic        md;
        logic        sg;
        logic        fl;
        int          fat;
        logic [10:0] exp;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0: begin op = 3'd7; fn = rfn[$urandom_range(0, 10)]; end
                1: begin op = 3'($urandom_range(3, 6)); fn = 6'($urandom); end
                default: begin op = 3'($urandom); fn = 6'($urandom); end
            endcase
            ref_decode(op, fn, code, md, sg);
            if (md) begin
                fat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MDC - 1)) : -1;
                md_sequence(op, fn, fat, 1'b0, "rnd_md");
            end else begin
                fl = ($urandom_range(0, 5) == 0);
                bus.valid_i = 1'b1;
                bus.flush_i = fl;
                bus.alu_op = op;
                bus.alu_function = fn;
                tick();
                bus.valid_i = 1'b0;
                bus.flush_i = 1'b0;
                if (!fl) m_code = code;
                exp = {!fl, 3'b001, 1'b0, m_code, 2'b00};
                total++;
                if (obs() !== exp) begin
                    bad++;
                    $display("FAIL rnd_%0d op=%0d fn=%0d got=%b want=%b", n, op, fn, obs(), exp);
                end
`ifdef ALU_CTRL_ILLEGAL_EN
                total++;
                if (bus.illegal_o !== (!fl && code == 4'd9)) begin
                    bad++;
                    $display("FAIL rnd_illegal_%0d got=%b want=%b", n, bus.illegal_o,
                             (!fl && code == 4'd9));
                end
`endif
                if ($urandom_range(0, 2) == 0) begin
                    tick();
                    exp = {4'b0001, 1'b0, m_code, 2'b00};
                    total++;
                    if (obs() !== exp) begin
                        bad++;
                        $display("FAIL rnd_gap_%0d got=%b want=%b", n, obs(), exp);
                    end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_mult();
        test_divu_flush();
        test_hold_during_iter();
        test_flush_idle();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
